// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: FSM states and
// the per-cycle pipeline control word with its canned bubble/stall patterns.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  typedef struct packed {
    logic pc_en;
    logic pc_sel;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic mem_wb_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_NORMAL   = 10'b10_1111_0000;
  localparam ctrl_t CTRL_REDIRECT = 10'b11_1111_1110;
  localparam ctrl_t CTRL_LU       = 10'b00_0111_0100;
  // Freeze still retires a bubble into MEM/WB so WB never repeats an instruction.
  localparam ctrl_t CTRL_FREEZE   = 10'b00_0001_0001;
  localparam ctrl_t CTRL_HALT     = 10'b00_0000_0000;
  localparam ctrl_t CTRL_RESET    = 10'b00_0000_1111;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline status inputs and sequencing control outputs of the hazard controller.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             ex_mem_read;
  logic [4:0]       ex_rt;
  logic             mem_branch;
  logic             mem_zero;
  logic             mem_jump;
  logic             mem_read;
  logic             mem_write;
  logic             dmem_ready;
  logic             pc_en;
  logic             pc_sel;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic             mem_wb_flush;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rt,
           mem_branch, mem_zero, mem_jump, mem_read, mem_write, dmem_ready,
    input  pc_en, pc_sel, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
           mem_timeout, stall_count, flush_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rt,
           mem_branch, mem_zero, mem_jump, mem_read, mem_write, dmem_ready,
    output pc_en, pc_sel, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
           mem_timeout, stall_count, flush_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Load-use comparator: the load in EX writes a register the ID instruction reads.
module pipe_hazard_ctrl_load_use_detect (
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  output logic       lu
);
  logic w_rs_hit;
  logic w_rt_hit;

  assign w_rs_hit = id_uses_rs & (id_rs == ex_rt);
  assign w_rt_hit = id_uses_rt & (id_rt == ex_rt);
  assign lu       = ex_mem_read & (ex_rt != 5'd0) & (w_rs_hit | w_rt_hit);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline sequencing: load-use stalls, MEM-resolved redirects and
// data-memory wait states with timeout, plus saturating stall/flush counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int              WC_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(MAX_WAIT);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WC_W-1:0]  r_wait_cnt;
  logic [WC_W-1:0]  w_wait_cnt_nxt;
  logic             r_timeout;
  logic [CNT_W-1:0] r_stall_count;
  logic [CNT_W-1:0] r_flush_count;
  logic             w_miss;
  logic             w_redirect;
  logic             w_lu;
  logic             w_redirect_act;
  logic             w_stall;
  ctrl_t            w_run_ctrl;
  ctrl_t            w_ctrl;

  pipe_hazard_ctrl_load_use_detect u_lud (
    .ex_mem_read (bus.ex_mem_read),
    .ex_rt       (bus.ex_rt),
    .id_rs       (bus.id_rs),
    .id_rt       (bus.id_rt),
    .id_uses_rs  (bus.id_uses_rs),
    .id_uses_rt  (bus.id_uses_rt),
    .lu          (w_lu)
  );

  assign w_miss     = (bus.mem_read | bus.mem_write) & ~bus.dmem_ready;
  assign w_redirect = (bus.mem_branch & bus.mem_zero) | bus.mem_jump;
  assign w_run_ctrl = w_redirect ? CTRL_REDIRECT : (w_lu ? CTRL_LU : CTRL_NORMAL);

  always_comb begin
    w_ctrl         = CTRL_HALT;
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_redirect_act = 1'b0;
    case (r_state)
      RUN: begin
        if (w_miss) begin
          w_ctrl         = CTRL_FREEZE;
          w_state_nxt    = MEM_WAIT;
          w_wait_cnt_nxt = WC_W'(1);
        end else begin
          w_ctrl         = w_run_ctrl;
          w_redirect_act = w_redirect;
        end
      end
      MEM_WAIT: begin
        if (bus.dmem_ready) begin
          w_ctrl         = w_run_ctrl;
          w_redirect_act = w_redirect;
          w_state_nxt    = RUN;
          w_wait_cnt_nxt = '0;
        end else if (r_wait_cnt == WC_MAX) begin
          w_ctrl      = CTRL_FREEZE;
          w_state_nxt = HALT;
        end else begin
          w_ctrl         = CTRL_FREEZE;
          w_wait_cnt_nxt = r_wait_cnt + 1'b1;
        end
      end
      HALT: begin
        w_ctrl = CTRL_HALT;
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
    if (rst) begin
      w_ctrl         = CTRL_RESET;
      w_redirect_act = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_state_nxt == HALT) r_timeout <= 1'b1;
    end
  end

  assign w_stall = ~rst & (r_state != HALT) & ~w_ctrl.pc_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (w_stall && (r_stall_count != '1)) r_stall_count <= r_stall_count + 1'b1;
      if (w_redirect_act && (r_flush_count != '1)) r_flush_count <= r_flush_count + 1'b1;
    end
  end

  assign {bus.pc_en, bus.pc_sel, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
          bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush, bus.mem_wb_flush} = w_ctrl;
  assign bus.mem_timeout = r_timeout;
  assign bus.stall_count = r_stall_count;
  assign bus.flush_count = r_flush_count;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus a random run
// compared against a cycle-level behavioural model of the sequencing rules.
module tb_pipe_hazard_ctrl;
  localparam int MAXW = 4;
  localparam int CW   = 4;
  localparam int SAT  = (1 << CW) - 1;

  // {pc_en,pc_sel,if_id_en,id_ex_en,ex_mem_en,mem_wb_en,if_id_fl,id_ex_fl,ex_mem_fl,mem_wb_fl}
  localparam logic [9:0] V_NORMAL = 10'b1011110000;
  localparam logic [9:0] V_REDIR  = 10'b1111111110;
  localparam logic [9:0] V_LU     = 10'b0001110100;
  localparam logic [9:0] V_FREEZE = 10'b0000010001;
  localparam logic [9:0] V_HALT   = 10'b0000000000;
  localparam logic [9:0] V_RESET  = 10'b0000001111;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();

  pipe_hazard_ctrl #(.MAX_WAIT(MAXW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [9:0] act_vec;
  assign act_vec = {bus.pc_en, bus.pc_sel, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en,
                    bus.mem_wb_en, bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush,
                    bus.mem_wb_flush};

  int checks = 0;
  int errors = 0;

  // Model: m_frozen = frozen cycles already spent in the current memory stall.
  bit         m_halt, m_tmo, e_miss, e_redir_act;
  int         m_frozen, m_stall, m_flush;
  logic [9:0] exp_vec;

  task automatic idle();
    bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rs = 1'b0; bus.id_uses_rt = 1'b0;
    bus.ex_mem_read = 1'b0; bus.ex_rt = '0;
    bus.mem_branch = 1'b0; bus.mem_zero = 1'b0; bus.mem_jump = 1'b0;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.dmem_ready = 1'b0;
  endtask

  task automatic settle();
    bit redir, lu, waiting;
    #1;
    e_miss  = (bus.mem_read || bus.mem_write) && !bus.dmem_ready;
    redir   = (bus.mem_branch && bus.mem_zero) || bus.mem_jump;
    lu      = 1'b0;
    if (bus.ex_mem_read && bus.ex_rt != 5'd0)
      lu = (bus.id_uses_rs && bus.id_rs == bus.ex_rt) || (bus.id_uses_rt && bus.id_rt == bus.ex_rt);
    waiting     = (m_frozen > 0);
    e_redir_act = 1'b0;
    if (rst)                                                  exp_vec = V_RESET;
    else if (m_halt)                                          exp_vec = V_HALT;
    else if ((waiting && !bus.dmem_ready) || (!waiting && e_miss)) exp_vec = V_FREEZE;
    else if (redir) begin exp_vec = V_REDIR; e_redir_act = 1'b1; end
    else if (lu)                                              exp_vec = V_LU;
    else                                                      exp_vec = V_NORMAL;
  endtask

  task automatic tick();
    settle();
    if (rst) begin
      m_halt = 0; m_tmo = 0; m_frozen = 0; m_stall = 0; m_flush = 0;
    end else if (!m_halt) begin
      if (!exp_vec[9] && m_stall < SAT) m_stall++;
      if (e_redir_act && m_flush < SAT) m_flush++;
      if (m_frozen > 0) begin
        if (bus.dmem_ready) m_frozen = 0;
        else if (m_frozen + 1 == 1 + MAXW) begin m_halt = 1; m_tmo = 1; m_frozen = 0; end
        else m_frozen++;
      end else if (e_miss) begin
        m_frozen = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    bus.mem_read = 1'b1; bus.mem_jump = 1'b1;
    rst = 1'b1;
    #1;
    if (act_vec !== V_RESET) begin $display("FAIL reset_vec got=%b exp=%b", act_vec, V_RESET); errors++; end
    checks++;
    tick();
    rst = 1'b0;
    idle();
    #1;
    if (bus.stall_count !== 4'd0 || bus.flush_count !== 4'd0 || bus.mem_timeout !== 1'b0) begin
      $display("FAIL reset_state got=%0d/%0d/%b exp=0/0/0", bus.stall_count, bus.flush_count, bus.mem_timeout);
      errors++;
    end
    checks++;
    if (act_vec !== V_NORMAL) begin $display("FAIL reset_idle_vec got=%b exp=%b", act_vec, V_NORMAL); errors++; end
    checks++;
  endtask

  task automatic test_load_use();
    do_reset();
    bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd5; bus.id_rs = 5'd5; bus.id_uses_rs = 1'b1;
    #1;
    if (act_vec !== V_LU) begin $display("FAIL lu_vec got=%b exp=%b", act_vec, V_LU); errors++; end
    checks++;
    tick();
    idle();
    #1;
    if (act_vec !== V_NORMAL) begin $display("FAIL lu_after got=%b exp=%b", act_vec, V_NORMAL); errors++; end
    checks++;
    if (bus.stall_count !== 4'd1) begin $display("FAIL lu_stall_count got=%0d exp=1", bus.stall_count); errors++; end
    checks++;
  endtask

  task automatic test_no_stall();
    do_reset();
    bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd0; bus.id_rs = 5'd0; bus.id_uses_rs = 1'b1;
    #1;
    if (act_vec !== V_NORMAL) begin $display("FAIL lu_r0 got=%b exp=%b", act_vec, V_NORMAL); errors++; end
    checks++;
    tick();
    bus.ex_rt = 5'd9; bus.id_rs = 5'd9; bus.id_rt = 5'd9; bus.id_uses_rs = 1'b0; bus.id_uses_rt = 1'b0;
    #1;
    if (act_vec !== V_NORMAL) begin $display("FAIL lu_unused got=%b exp=%b", act_vec, V_NORMAL); errors++; end
    checks++;
    tick();
    bus.id_uses_rt = 1'b1;
    #1;
    if (act_vec !== V_LU) begin $display("FAIL lu_rt got=%b exp=%b", act_vec, V_LU); errors++; end
    checks++;
    tick();
    idle();
    #1;
    if (bus.stall_count !== 4'd1) begin $display("FAIL no_stall_count got=%0d exp=1", bus.stall_count); errors++; end
    checks++;
  endtask

  task automatic test_branch();
    do_reset();
    bus.mem_branch = 1'b1; bus.mem_zero = 1'b1;
    bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd3; bus.id_rs = 5'd3; bus.id_uses_rs = 1'b1;
    #1;
    if (act_vec !== V_REDIR) begin $display("FAIL branch_vec got=%b exp=%b", act_vec, V_REDIR); errors++; end
    checks++;
    tick();
    idle();
    bus.mem_branch = 1'b1;
    #1;
    if (bus.flush_count !== 4'd1 || bus.stall_count !== 4'd0) begin
      $display("FAIL branch_counts got=%0d/%0d exp=1/0", bus.flush_count, bus.stall_count); errors++;
    end
    checks++;
    if (act_vec !== V_NORMAL) begin $display("FAIL branch_not_taken got=%b exp=%b", act_vec, V_NORMAL); errors++; end
    checks++;
    tick();
    idle();
    bus.mem_jump = 1'b1;
    #1;
    if (act_vec !== V_REDIR) begin $display("FAIL jump_vec got=%b exp=%b", act_vec, V_REDIR); errors++; end
    checks++;
    tick();
    idle();
    #1;
    if (bus.flush_count !== 4'd2) begin $display("FAIL jump_flush_count got=%0d exp=2", bus.flush_count); errors++; end
    checks++;
  endtask

  task automatic test_mem_wait();
    do_reset();
    bus.mem_read = 1'b1; bus.dmem_ready = 1'b1;
    #1;
    if (act_vec !== V_NORMAL) begin $display("FAIL zero_wait got=%b exp=%b", act_vec, V_NORMAL); errors++; end
    checks++;
    tick();
    bus.dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (act_vec !== V_FREEZE) begin $display("FAIL wait_freeze%0d got=%b exp=%b", i, act_vec, V_FREEZE); errors++; end
      checks++;
      tick();
    end
    bus.dmem_ready = 1'b1;
    bus.mem_read = 1'b0;
    #1;
    if (act_vec !== V_NORMAL) begin $display("FAIL wait_release got=%b exp=%b", act_vec, V_NORMAL); errors++; end
    checks++;
    tick();
    idle();
    #1;
    if (bus.stall_count !== 4'd3) begin $display("FAIL wait_stall_count got=%0d exp=3", bus.stall_count); errors++; end
    checks++;
  endtask

  task automatic test_wait_boundary();
    do_reset();
    bus.mem_write = 1'b1;
    for (int i = 0; i < MAXW; i++) tick();
    bus.dmem_ready = 1'b1;
    bus.mem_jump = 1'b1;
    #1;
    if (act_vec !== V_REDIR) begin $display("FAIL last_cycle_release got=%b exp=%b", act_vec, V_REDIR); errors++; end
    checks++;
    tick();
    idle();
    #1;
    if (bus.mem_timeout !== 1'b0 || bus.flush_count !== 4'd1 || act_vec !== V_NORMAL) begin
      $display("FAIL boundary_after got=%b/%0d/%b exp=0/1/%b", bus.mem_timeout, bus.flush_count, act_vec, V_NORMAL);
      errors++;
    end
    checks++;
  endtask

  task automatic test_timeout();
    do_reset();
    bus.mem_write = 1'b1;
    for (int i = 0; i < MAXW + 1; i++) begin
      #1;
      if (act_vec !== V_FREEZE) begin $display("FAIL tmo_freeze%0d got=%b exp=%b", i, act_vec, V_FREEZE); errors++; end
      checks++;
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      bus.dmem_ready = 1'(i);
      bus.mem_jump = 1'b1;
      #1;
      if (act_vec !== V_HALT || bus.mem_timeout !== 1'b1) begin
        $display("FAIL halt%0d got=%b/%b exp=%b/1", i, act_vec, bus.mem_timeout, V_HALT); errors++;
      end
      checks++;
      tick();
    end
    if (bus.stall_count !== 4'(MAXW + 1) || bus.flush_count !== 4'd0) begin
      $display("FAIL halt_counts got=%0d/%0d exp=%0d/0", bus.stall_count, bus.flush_count, MAXW + 1); errors++;
    end
    checks++;
    do_reset();
    #1;
    if (bus.mem_timeout !== 1'b0) begin $display("FAIL tmo_cleared got=%b exp=0", bus.mem_timeout); errors++; end
    checks++;
  endtask

  task automatic test_miss_plus_lu();
    do_reset();
    bus.mem_read = 1'b1;
    bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd7; bus.id_rt = 5'd7; bus.id_uses_rt = 1'b1;
    #1;
    if (act_vec !== V_FREEZE) begin $display("FAIL miss_lu_freeze got=%b exp=%b", act_vec, V_FREEZE); errors++; end
    checks++;
    tick();
    bus.dmem_ready = 1'b1;
    #1;
    if (act_vec !== V_LU) begin $display("FAIL miss_lu_release got=%b exp=%b", act_vec, V_LU); errors++; end
    checks++;
    tick();
    idle();
    #1;
    if (act_vec !== V_NORMAL || bus.stall_count !== 4'd2) begin
      $display("FAIL miss_lu_after got=%b/%0d exp=%b/2", act_vec, bus.stall_count, V_NORMAL); errors++;
    end
    checks++;
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    bus.mem_jump = 1'b1;
    tick();
    idle();
    bus.mem_read = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #1;
    if (act_vec !== V_RESET) begin $display("FAIL mid_wait_rst_vec got=%b exp=%b", act_vec, V_RESET); errors++; end
    checks++;
    tick();
    rst = 1'b0;
    idle();
    #1;
    if (act_vec !== V_NORMAL || bus.stall_count !== 4'd0 || bus.flush_count !== 4'd0) begin
      $display("FAIL mid_wait_after got=%b/%0d/%0d exp=%b/0/0", act_vec, bus.stall_count, bus.flush_count, V_NORMAL);
      errors++;
    end
    checks++;
  endtask

  task automatic test_saturation();
    do_reset();
    bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd4; bus.id_rs = 5'd4; bus.id_uses_rs = 1'b1;
    for (int i = 0; i < SAT + 4; i++) tick();
    idle();
    bus.mem_jump = 1'b1;
    for (int i = 0; i < SAT + 4; i++) tick();
    idle();
    #1;
    if (bus.stall_count !== 4'(SAT) || bus.flush_count !== 4'(SAT)) begin
      $display("FAIL saturation got=%0d/%0d exp=%0d/%0d", bus.stall_count, bus.flush_count, SAT, SAT); errors++;
    end
    checks++;
  endtask

  task automatic test_random();
    int halted_for;
    do_reset();
    halted_for = 0;
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 299) == 0) || (halted_for > 12);
      bus.id_rs       = 5'($urandom_range(0, 7));
      bus.id_rt       = 5'($urandom_range(0, 7));
      bus.id_uses_rs  = 1'($urandom_range(0, 1));
      bus.id_uses_rt  = 1'($urandom_range(0, 1));
      bus.ex_mem_read = 1'($urandom_range(0, 1));
      bus.ex_rt       = 5'($urandom_range(0, 7));
      bus.mem_branch  = ($urandom_range(0, 3) == 0);
      bus.mem_zero    = 1'($urandom_range(0, 1));
      bus.mem_jump    = ($urandom_range(0, 7) == 0);
      bus.mem_read    = ($urandom_range(0, 3) == 0);
      bus.mem_write   = ($urandom_range(0, 7) == 0);
      bus.dmem_ready  = ($urandom_range(0, 9) < ((i / 250) % 2 == 0 ? 7 : 2));
      settle();
      if (act_vec !== exp_vec) begin $display("FAIL rand_vec@%0d got=%b exp=%b", i, act_vec, exp_vec); errors++; end
      checks++;
      if (bus.stall_count !== CW'(m_stall) || bus.flush_count !== CW'(m_flush) || bus.mem_timeout !== m_tmo) begin
        $display("FAIL rand_state@%0d got=%0d/%0d/%b exp=%0d/%0d/%b", i, bus.stall_count, bus.flush_count,
                 bus.mem_timeout, m_stall, m_flush, m_tmo);
        errors++;
      end
      checks++;
      halted_for = m_halt ? halted_for + 1 : 0;
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    m_halt = 0; m_tmo = 0; m_frozen = 0; m_stall = 0; m_flush = 0;
    idle();
    rst = 1'b1;
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch();
    test_mem_wait();
    test_wait_boundary();
    test_timeout();
    test_miss_plus_lu();
    test_reset_mid_wait();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
